axis_abs_log_conv: RTL and testbench

//  Pipelined fixed-point logarithm for the control-source path. Consumes the unsigned magnitude

---
 rtl/axis_abs_log_conv.sv | 116 +++++++++++
 tb/tb_axis_abs_log_conv.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_abs_log_conv.sv
// rtl/axis_abs_log_conv.sv - pipelined fixed-point log2/ln of an unsigned magnitude stream
// Leading-one detect, Mitchell mantissa, 16-segment midpoint correction; fixed 5-cycle latency.
module axis_abs_log_conv #(
    parameter int IN_WIDTH  = 32,
    parameter int FRAC_BITS = 24,
    parameter int LN_MODE   = 1,
    parameter int LN2_Q16   = 45426
) (
    input  logic                a_clk,
    input  logic                a_reset,
    input  logic [IN_WIDTH-1:0] S_AXIS_tdata,
    input  logic                S_AXIS_tvalid,
    input  logic [31:0]         log_offset,
    output logic [31:0]         M_AXIS_tdata,
    output logic                M_AXIS_tvalid,
    output logic                M_AXIS_zero
);

    // Midpoint residual of log2(1+m) - m for each of the 16 mantissa segments.
    function automatic logic [31:0] corr_entry(input int i);
        real m;
        real g;
        m = (real'(i) + 0.5) / 16.0;
        g = ($ln(1.0 + m) / $ln(2.0) - m) * (2.0 ** FRAC_BITS);
        return 32'($rtoi(g + 0.5));
    endfunction

    logic [31:0] w_corr [16];
    for (genvar gi = 0; gi < 16; gi++) begin : g_corr
        assign w_corr[gi] = corr_entry(gi);
    end

    logic [4:0]                    r_vld;
    logic [IN_WIDTH-1:0]           r_s1_x;
    logic [IN_WIDTH-1:0]           r_s2_x;
    logic                          r_s1_z;
    logic                          r_s2_z;
    logic                          r_s3_z;
    logic                          r_s4_z;
    logic [5:0]                    r_s2_e;
    logic [5:0]                    r_s3_e;
    logic [FRAC_BITS-1:0]          r_s3_f;
    logic [31:0]                   r_s4_l2;
    logic [31:0]                   r_tdata;
    logic                          r_zero;

    logic [5:0]                    w_e;
    logic [IN_WIDTH-1:0]           w_norm;
    logic [IN_WIDTH+FRAC_BITS-1:0] w_ext;
    logic [FRAC_BITS-1:0]          w_f;
    logic [31:0]                   w_l2;
    logic signed [47:0]            w_l2_ext;
    logic signed [47:0]            w_ln2;
    logic signed [47:0]            w_prod;
    logic [31:0]                   w_r;

    // Highest set bit wins; x==0 leaves e at 0.
    always_comb begin
        w_e = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (r_s1_x[i]) begin
                w_e = 6'(i);
            end
        end
    end

    // Leading one lands on the MSB; the bits beneath it form the left-aligned mantissa.
    assign w_norm   = r_s2_x << (6'(IN_WIDTH - 1) - r_s2_e);
    assign w_ext    = {w_norm, {FRAC_BITS{1'b0}}};
    assign w_f      = FRAC_BITS'(w_ext >> (IN_WIDTH - 1));

    assign w_l2     = (32'(r_s3_e) << FRAC_BITS) + 32'(r_s3_f)
                      + w_corr[r_s3_f[FRAC_BITS-1 -: 4]];

    assign w_l2_ext = 48'($signed(r_s4_l2));
    assign w_ln2    = 48'(LN2_Q16);
    assign w_prod   = w_l2_ext * w_ln2;
    assign w_r      = (LN_MODE != 0) ? 32'(w_prod >>> 16) : r_s4_l2;

    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) begin
            r_vld   <= '0;
            r_s1_x  <= '0;
            r_s2_x  <= '0;
            r_s1_z  <= 1'b0;
            r_s2_z  <= 1'b0;
            r_s3_z  <= 1'b0;
            r_s4_z  <= 1'b0;
            r_s2_e  <= '0;
            r_s3_e  <= '0;
            r_s3_f  <= '0;
            r_s4_l2 <= '0;
            r_tdata <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_vld   <= {r_vld[3:0], S_AXIS_tvalid};
            r_s1_x  <= S_AXIS_tdata;
            r_s1_z  <= (S_AXIS_tdata == '0);
            r_s2_x  <= r_s1_x;
            r_s2_e  <= w_e;
            r_s2_z  <= r_s1_z;
            r_s3_e  <= r_s2_e;
            r_s3_f  <= w_f;
            r_s3_z  <= r_s2_z;
            r_s4_l2 <= w_l2;
            r_s4_z  <= r_s3_z;
            r_tdata <= r_s4_z ? 32'h8000_0000 : (w_r + log_offset);
            r_zero  <= r_s4_z;
        end
    end

    assign M_AXIS_tdata  = r_tdata;
    assign M_AXIS_tvalid = r_vld[4];
    assign M_AXIS_zero   = r_zero;

endmodule

// File: tb/tb_axis_abs_log_conv.sv
// tb/tb_axis_abs_log_conv.sv - scoreboard bench for axis_abs_log_conv in log2 and ln modes
module tb_axis_abs_log_conv;

    localparam real TWO24 = 16777216.0;

    logic        a_clk      = 1'b0;
    logic        a_reset    = 1'b1;
    logic [31:0] s_tdata    = '0;
    logic        s_tvalid   = 1'b0;
    logic [31:0] log_offset = '0;

    logic [31:0] l2_tdata;
    logic        l2_tvalid;
    logic        l2_zero;
    logic [31:0] ln_tdata;
    logic        ln_tvalid;
    logic        ln_zero;

    always #5 a_clk = ~a_clk;

    axis_abs_log_conv #(.IN_WIDTH(32), .FRAC_BITS(24), .LN_MODE(0), .LN2_Q16(45426)) u_l2 (
        .a_clk(a_clk), .a_reset(a_reset),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .log_offset(log_offset),
        .M_AXIS_tdata(l2_tdata), .M_AXIS_tvalid(l2_tvalid), .M_AXIS_zero(l2_zero)
    );

    axis_abs_log_conv #(.IN_WIDTH(32), .FRAC_BITS(24), .LN_MODE(1), .LN2_Q16(45426)) u_ln (
        .a_clk(a_clk), .a_reset(a_reset),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .log_offset(log_offset),
        .M_AXIS_tdata(ln_tdata), .M_AXIS_tvalid(ln_tvalid), .M_AXIS_zero(ln_zero)
    );

    typedef struct {
        int unsigned cyc;
        logic        vld;
        logic [31:0] x;
        logic [31:0] off;
        logic        l2_ex;
        logic [31:0] l2_exp;
        logic        ln_ex;
        logic [31:0] ln_exp;
    } beat_t;

    beat_t       sb[$];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] c0;

    always @(posedge a_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [31:0] data, input logic [31:0] off,
                           input real rv, input real tol);
        int  di;
        real d;
        di = $signed(data - off);
        d  = real'(di);
        checks++;
        assert ((d - rv <= tol) && (rv - d <= tol)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (+/-%0d)", tag, di, $rtoi(rv), $rtoi(tol));
        end
    endtask

    task automatic check_beat(input beat_t b);
        real lx;
        if (b.x == 0) begin
            chk("l2_zero_data", l2_tdata, 32'h8000_0000);
            chk("l2_zero_flag", 32'(l2_zero), 32'd1);
            chk("ln_zero_data", ln_tdata, 32'h8000_0000);
            chk("ln_zero_flag", 32'(ln_zero), 32'd1);
        end else begin
            lx = $ln(real'(b.x));
            chk("l2_flag", 32'(l2_zero), 32'd0);
            chk("ln_flag", 32'(ln_zero), 32'd0);
            if (b.l2_ex) chk("l2_exact", l2_tdata, b.l2_exp);
            else         chk_tol("l2_tol", l2_tdata, b.off, lx / $ln(2.0) * TWO24, 0.015 * TWO24);
            if (b.ln_ex) chk("ln_exact", ln_tdata, b.ln_exp);
            else         chk_tol("ln_tol", ln_tdata, b.off, lx * TWO24, 0.011 * TWO24);
        end
    endtask

    always @(negedge a_clk) begin
        if (!a_reset) begin
            if (sb.size() > 0 && sb[0].cyc + 4 == cyc) begin
                beat_t b;
                b = sb.pop_front();
                chk("l2_vld", 32'(l2_tvalid), 32'(b.vld));
                chk("ln_vld", 32'(ln_tvalid), 32'(b.vld));
                if (b.vld) check_beat(b);
            end else begin
                chk("l2_idle_vld", 32'(l2_tvalid), 32'd0);
                chk("ln_idle_vld", 32'(ln_tvalid), 32'd0);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] x,
                         input logic l2e, input logic [31:0] l2x,
                         input logic lne, input logic [31:0] lnx);
        beat_t b;
        s_tvalid = v;
        s_tdata  = x;
        b.cyc    = cyc + 1;
        b.vld    = v;
        b.x      = x;
        b.off    = log_offset;
        b.l2_ex  = l2e;
        b.l2_exp = l2x;
        b.ln_ex  = lne;
        b.ln_exp = lnx;
        sb.push_back(b);
        @(posedge a_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, $urandom, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_l2_data"}, l2_tdata, 32'd0);
        chk({tag, "_l2_vld"},  32'(l2_tvalid), 32'd0);
        chk({tag, "_l2_zf"},   32'(l2_zero), 32'd0);
        chk({tag, "_ln_data"}, ln_tdata, 32'd0);
        chk({tag, "_ln_vld"},  32'(ln_tvalid), 32'd0);
        chk({tag, "_ln_zf"},   32'(ln_zero), 32'd0);
    endtask

    initial begin
        longint      ln1;
        logic [31:0] x;
        c0  = 32'($rtoi(($ln(1.0 + 1.0 / 32.0) / $ln(2.0) - 1.0 / 32.0) * TWO24 + 0.5));
        ln1 = (longint'(c0) * 45426) >>> 16;

        repeat (3) @(posedge a_clk);
        #1;
        chk_all_zero("reset");
        a_reset = 1'b0;
        idle(2);

        // powers of two: exact log2 and latency
        log_offset = 32'd0;
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, 32'd1 << k, 1'b1, (32'(k) << 24) + c0, 1'b0, '0);
        end
        idle(6);

        // natural log accuracy, plus exact ln(1)
        drive(1'b1, 32'd1, 1'b1, c0, 1'b1, 32'(ln1));
        drive(1'b1, 32'd2, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 32'd1000, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 32'd1 << 20, 1'b0, '0, 1'b0, '0);
        idle(6);

        // zero input ignores the offset; the next beat is normal
        log_offset = 32'h0100_0000;
        drive(1'b1, 32'd0, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 32'd4, 1'b1, (32'd2 << 24) + c0 + 32'h0100_0000, 1'b0, '0);
        idle(6);

        // offset wraps without saturation; full-scale input
        log_offset = 32'h7FFF_FFFF;
        drive(1'b1, 32'h8000_0000, 1'b1, (32'd31 << 24) + c0 + 32'h7FFF_FFFF, 1'b0, '0);
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, '0);
        idle(6);

        // random stream with 50% valid
        log_offset = 32'h0012_3456;
        for (int i = 0; i < 10000; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            drive(1'(($urandom_range(0, 1))), x, 1'b0, '0, 1'b0, '0);
        end
        idle(6);

        // reset in the middle of a continuous burst
        log_offset = 32'd0;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'd1000 + 32'(i), 1'b0, '0, 1'b0, '0);
        a_reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        sb.delete();
        s_tvalid = 1'b0;
        @(posedge a_clk);
        #1;
        chk_all_zero("midrst_hold");
        a_reset = 1'b0;
        idle(2);
        for (int i = 0; i < 8; i++) drive(1'b1, 32'd77 + 32'(i * 3), 1'b0, '0, 1'b0, '0);
        idle(6);

        s_tvalid = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge a_clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
